z80_incdec_sequencer: RTL and testbench



---
 rtl/z80_incdec_pkg.sv | 45 ++++
 rtl/z80_incdec_alu.sv | 32 +++
 rtl/z80_incdec_sequencer.sv | 156 +++++++++++++++
 tb/tb_z80_incdec_sequencer.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/z80_incdec_pkg.sv
// z80_incdec_pkg: shared types and constants for the INC r / DEC r sequencer
// and its ALU. Register codes follow the Z80 "r" field encoding.
package z80_incdec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_RETIRE,
        ST_TRAP
    } state_t;

    // Z80 "r" field encoding; code 6 is (HL), which this block never executes.
    localparam logic [2:0] REG_B      = 3'd0;
    localparam logic [2:0] REG_C      = 3'd1;
    localparam logic [2:0] REG_D      = 3'd2;
    localparam logic [2:0] REG_E      = 3'd3;
    localparam logic [2:0] REG_H      = 3'd4;
    localparam logic [2:0] REG_L      = 3'd5;
    localparam logic [2:0] REG_HL_IND = 3'd6;
    localparam logic [2:0] REG_A      = 3'd7;

    // F register layout {S,Z,F5,H,F3,V,N,C}.
    localparam logic [7:0] FLAG_S_BIT  = 8'h80;
    localparam logic [7:0] FLAG_Z_BIT  = 8'h40;
    localparam logic [7:0] FLAG_F5_BIT = 8'h20;
    localparam logic [7:0] FLAG_H_BIT  = 8'h10;
    localparam logic [7:0] FLAG_F3_BIT = 8'h08;
    localparam logic [7:0] FLAG_V_BIT  = 8'h04;
    localparam logic [7:0] FLAG_N_BIT  = 8'h02;
    localparam logic [7:0] FLAG_C_BIT  = 8'h01;

    // Flags INC/DEC pass through unchanged from the current F.
    localparam logic [7:0] FLAG_KEEP_MASK = FLAG_F5_BIT | FLAG_F3_BIT | FLAG_C_BIT;

    // INC r = 00rrr100, DEC r = 00rrr101: bits[7:6]=00 and bits[2:1]=10.
    localparam logic [7:0] OP_INCDEC_MASK  = 8'hC6;
    localparam logic [7:0] OP_INCDEC_MATCH = 8'h04;

    // True for INC r / DEC r with a plain register operand.
    function automatic logic is_incdec(input logic [7:0] op);
        return ((op & OP_INCDEC_MASK) == OP_INCDEC_MATCH) && (op[5:3] != REG_HL_IND);
    endfunction

endpackage

// File: rtl/z80_incdec_alu.sv
// z80_incdec_alu: combinational 8-bit increment/decrement with Z80 flag
// generation. S, Z, H, V and N are computed; F5, F3 and C pass through.
module z80_incdec_alu
    import z80_incdec_pkg::*;
(
    input  logic [7:0] operand,
    input  logic       is_dec,
    input  logic [7:0] f_in,
    output logic [7:0] result,
    output logic [7:0] flags
);

    // Compute the mod-256 result and assemble the new F value.
    always_comb begin
        // NOTE: every output gets a default before any conditional update, so no latch is inferred.
        result = is_dec ? (operand - 8'd1) : (operand + 8'd1);
        flags  = f_in & FLAG_KEEP_MASK;
        if (result[7]) flags = flags | FLAG_S_BIT;
        if (result == 8'h00) flags = flags | FLAG_Z_BIT;
        if (is_dec) begin
            // Borrow out of the low nibble, and signed overflow from 0x80.
            if (operand[3:0] == 4'h0) flags = flags | FLAG_H_BIT;
            if (operand == 8'h80) flags = flags | FLAG_V_BIT;
            flags = flags | FLAG_N_BIT;
        end else begin
            // Carry out of the low nibble, and signed overflow from 0x7F.
            if (operand[3:0] == 4'hF) flags = flags | FLAG_H_BIT;
            if (operand == 8'h7F) flags = flags | FLAG_V_BIT;
        end
    end

endmodule

// File: rtl/z80_incdec_sequencer.sv
// z80_incdec_sequencer: fetches an opcode at IP, executes INC r / DEC r in a
// single EXEC cycle (register and flag writeback together), then retires and
// advances IP. Any other opcode parks the block in TRAP until reset.
// Define Z80FI_EN to add the formal-interface retirement record outputs.
module z80_incdec_sequencer
    import z80_incdec_pkg::*;
#(
    parameter logic [15:0] RESET_IP = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic        mem_ready,
    input  logic [7:0]  mem_data,
    output logic [2:0]  rf_raddr,
    input  logic [7:0]  rf_rdata,
    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic [7:0]  rf_wdata,
    input  logic [7:0]  f_in,
    output logic        f_we,
    output logic [7:0]  f_wdata,
    output logic [15:0] ip,
    output logic        busy,
    output logic        illegal,
`ifdef Z80FI_EN
    output logic        z80fi_valid,
    output logic [7:0]  z80fi_insn,
    output logic [3:0]  z80fi_insn_len,
    output logic [15:0] z80fi_reg_ip_in,
    output logic [7:0]  z80fi_reg_f_in,
    output logic [7:0]  z80fi_reg_f_out,
`endif
    output logic        retire
);

    state_t      state, state_nxt;
    logic [15:0] ip_q;
    logic [2:0]  reg_q;   // latched r field
    logic        dec_q;   // latched opcode[0]: 1 = DEC
    logic [7:0]  alu_result;
    logic [7:0]  alu_flags;

    z80_incdec_alu u_alu (
        .operand (rf_rdata),
        .is_dec  (dec_q),
        .f_in    (f_in),
        .result  (alu_result),
        .flags   (alu_flags)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Instruction pointer: advances once per retired instruction, wraps at 16 bits.
    always_ff @(posedge clk) begin
        if (reset)                   ip_q <= RESET_IP;
        else if (state == ST_RETIRE) ip_q <= ip_q + 16'd1;
    end

    // Opcode latch: only the fields EXEC needs are kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_q <= 3'd0;
            dec_q <= 1'b0;
        end else if (state == ST_FETCH && mem_ready) begin
            reg_q <= mem_data[5:3];
            dec_q <= mem_data[0];
        end
    end

    // Next-state and control outputs; strobes are suppressed on a reset cycle.
    always_comb begin
        state_nxt = state;
        mem_rd    = 1'b0;
        rf_we     = 1'b0;
        f_we      = 1'b0;
        retire    = 1'b0;
        rf_raddr  = REG_B;
        busy      = 1'b0;
        illegal   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                busy   = 1'b1;
                mem_rd = 1'b1;
                if (mem_ready) state_nxt = is_incdec(mem_data) ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                busy      = 1'b1;
                rf_raddr  = reg_q;
                rf_we     = 1'b1;
                f_we      = 1'b1;
                state_nxt = ST_RETIRE;
            end
            ST_RETIRE: begin
                busy      = 1'b1;
                retire    = 1'b1;
                state_nxt = run ? ST_FETCH : ST_IDLE;
            end
            ST_TRAP: begin
                illegal = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (reset) begin
            mem_rd = 1'b0;
            rf_we  = 1'b0;
            f_we   = 1'b0;
            retire = 1'b0;
        end
    end

    assign mem_addr = ip_q;
    assign ip       = ip_q;
    assign rf_waddr = reg_q;
    assign rf_wdata = alu_result;
    assign f_wdata  = alu_flags;

`ifdef Z80FI_EN
    logic [7:0] insn_q;
    logic [7:0] fi_f_in_q;
    logic [7:0] fi_f_out_q;

    // Retirement record capture: full opcode at fetch, F before/after at EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            insn_q     <= 8'h00;
            fi_f_in_q  <= 8'h00;
            fi_f_out_q <= 8'h00;
        end else begin
            if (state == ST_FETCH && mem_ready) insn_q <= mem_data;
            if (state == ST_EXEC) begin
                fi_f_in_q  <= f_in;
                fi_f_out_q <= alu_flags;
            end
        end
    end

    assign z80fi_valid     = retire;
    assign z80fi_insn      = insn_q;
    assign z80fi_insn_len  = 4'd1;
    assign z80fi_reg_ip_in = ip_q;
    assign z80fi_reg_f_in  = fi_f_in_q;
    assign z80fi_reg_f_out = fi_f_out_q;
`endif

endmodule

// File: tb/tb_z80_incdec_sequencer.sv
// tb_z80_incdec_sequencer: memory, register file and F register models around
// the sequencer, with a scoreboard of predicted register/flag writebacks.
`timescale 1ns/1ps
module tb_z80_incdec_sequencer;
    import z80_incdec_pkg::*;

    localparam logic [15:0] RESET_IP = 16'hFFFF;

    logic        clk = 1'b0;
    logic        reset, run;
    logic        mem_rd, mem_ready;
    logic [15:0] mem_addr, ip;
    logic [7:0]  mem_data, rf_rdata, rf_wdata, f_in, f_wdata;
    logic [2:0]  rf_raddr, rf_waddr;
    logic        rf_we, f_we, busy, illegal, retire;
`ifdef Z80FI_EN
    logic        z80fi_valid;
    logic [7:0]  z80fi_insn, z80fi_reg_f_in, z80fi_reg_f_out;
    logic [3:0]  z80fi_insn_len;
    logic [15:0] z80fi_reg_ip_in;
`endif

    z80_incdec_sequencer #(.RESET_IP(RESET_IP)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_ready (mem_ready),
        .mem_data  (mem_data),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .f_in      (f_in),
        .f_we      (f_we),
        .f_wdata   (f_wdata),
        .ip        (ip),
        .busy      (busy),
        .illegal   (illegal),
`ifdef Z80FI_EN
        .z80fi_valid     (z80fi_valid),
        .z80fi_insn      (z80fi_insn),
        .z80fi_insn_len  (z80fi_insn_len),
        .z80fi_reg_ip_in (z80fi_reg_ip_in),
        .z80fi_reg_f_in  (z80fi_reg_f_in),
        .z80fi_reg_f_out (z80fi_reg_f_out),
`endif
        .retire    (retire)
    );

    always #5 clk = ~clk;

    // Environment models: memory with programmable ready delay, register file, F.
    logic [7:0] mem [0:65535];
    logic [7:0] rf  [0:7];
    logic [7:0] f_reg;
    int         ready_delay = 0;
    int         wait_cnt = 0;

    assign mem_ready = mem_rd && (wait_cnt >= ready_delay);
    assign mem_data  = mem[mem_addr];
    assign rf_rdata  = rf[rf_raddr];
    assign f_in      = f_reg;

    always @(posedge clk) begin
        wait_cnt <= (mem_rd && !mem_ready) ? wait_cnt + 1 : 0;
        if (rf_we) rf[rf_waddr] <= rf_wdata;
        if (f_we)  f_reg <= f_wdata;
    end

    // Scoreboard of predicted writebacks and the predicted architectural state.
    typedef struct {
        logic [2:0] waddr;
        logic [7:0] wdata;
        logic [7:0] fdata;
    } exp_t;

    exp_t        sb[$];
    exp_t        sb_head;
    logic [7:0]  pred_rf [0:7];
    logic [7:0]  pred_f;
    logic [15:0] ip_model;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic set_reg(input logic [2:0] r, input logic [7:0] v);
        rf[r]      = v;
        pred_rf[r] = v;
    endtask

    task automatic set_f(input logic [7:0] v);
        f_reg  = v;
        pred_f = v;
    endtask

    // Predict INC/DEC from the bench's own register state and queue it.
    task automatic push_expect(input logic [7:0] op);
        logic [2:0] r;
        int         a, res;
        logic [7:0] fl;
        exp_t       e;
        r  = op[5:3];
        a  = int'(pred_rf[r]);
        res = op[0] ? (a + 255) % 256 : (a + 1) % 256;
        fl = pred_f & 8'h29;
        fl[7] = (res >= 128);
        fl[6] = (res == 0);
        fl[4] = op[0] ? ((a % 16) == 0) : ((a % 16) == 15);
        fl[2] = op[0] ? (a == 128) : (a == 127);
        fl[1] = op[0];
        e.waddr = r;
        e.wdata = res[7:0];
        e.fdata = fl;
        sb.push_back(e);
        pred_rf[r] = res[7:0];
        pred_f     = fl;
    endtask

    // Compare every write strobe against the head of the scoreboard.
    always @(negedge clk) begin
        if (rf_we || f_we) begin
            n_checks++;
            if (rf_we !== f_we) begin
                n_fail++;
                $display("FAIL strobe_pair: rf_we=%b f_we=%b, required equal", rf_we, f_we);
            end
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: waddr=%0d wdata=%h f_wdata=%h, required no write",
                         rf_waddr, rf_wdata, f_wdata);
            end else begin
                sb_head = sb.pop_front();
                if (rf_waddr !== sb_head.waddr || rf_wdata !== sb_head.wdata) begin
                    n_fail++;
                    $display("FAIL rf_write: waddr=%0d wdata=%h, required waddr=%0d wdata=%h",
                             rf_waddr, rf_wdata, sb_head.waddr, sb_head.wdata);
                end
                n_checks++;
                if (f_wdata !== sb_head.fdata) begin
                    n_fail++;
                    $display("FAIL f_write: f_wdata=%h, required %h", f_wdata, sb_head.fdata);
                end
            end
        end
    end

    // Execute one instruction at ip_model; run drops once the fetch starts.
    task automatic exec_one(input logic [7:0] op, input int delay, input string tag);
        int          rd_cycles, retires, cycles, retire_cycle;
        logic [15:0] ip0;
        logic [7:0]  f_before, f_after;
        rd_cycles = 0; retires = 0; cycles = 0; retire_cycle = 0;
        ip0 = ip_model;
        mem[ip0] = op;
        ready_delay = delay;
        f_before = pred_f;
        push_expect(op);
        f_after = pred_f;
        run = 1'b1;
        while (retires == 0 && cycles < 60) begin
            @(negedge clk);
            cycles++;
            if (mem_rd) begin
                rd_cycles++;
                run = 1'b0;
                n_checks++;
                if (mem_addr !== ip0) begin
                    n_fail++;
                    $display("FAIL %s mem_addr: got %h, required %h", tag, mem_addr, ip0);
                end
            end
            if (retire) begin
                retires++;
                retire_cycle = cycles;
                n_checks++;
                if (ip !== ip0) begin
                    n_fail++;
                    $display("FAIL %s ip_at_retire: got %h, required %h", tag, ip, ip0);
                end
`ifdef Z80FI_EN
                n_checks++;
                if (z80fi_valid !== 1'b1 || z80fi_insn !== op || z80fi_insn_len !== 4'd1 ||
                    z80fi_reg_ip_in !== ip0 || z80fi_reg_f_in !== f_before ||
                    z80fi_reg_f_out !== f_after) begin
                    n_fail++;
                    $display("FAIL %s z80fi: valid=%b insn=%h len=%0d ip_in=%h f_in=%h f_out=%h, required 1 %h 1 %h %h %h",
                             tag, z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_reg_ip_in,
                             z80fi_reg_f_in, z80fi_reg_f_out, op, ip0, f_before, f_after);
                end
`endif
            end
        end
        run = 1'b0;
        n_checks++;
        if (retires != 1 || retire_cycle != delay + 3) begin
            n_fail++;
            $display("FAIL %s retire_timing: retires=%0d at cycle %0d, required 1 at cycle %0d",
                     tag, retires, retire_cycle, delay + 3);
        end
        n_checks++;
        if (rd_cycles != delay + 1) begin
            n_fail++;
            $display("FAIL %s mem_rd_cycles: got %0d, required %0d", tag, rd_cycles, delay + 1);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || retire !== 1'b0 || ip !== ip0 + 16'd1) begin
            n_fail++;
            $display("FAIL %s after_retire: busy=%b retire=%b ip=%h, required 0 0 %h",
                     tag, busy, retire, ip, ip0 + 16'd1);
        end
        ip_model = ip0 + 16'd1;
    endtask

    // Wait (bounded) for the fetch request of an instruction.
    task automatic wait_fetch(input string tag);
        int n;
        n = 0;
        while (mem_rd !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (mem_rd !== 1'b1) begin
            n_fail++;
            $display("FAIL %s fetch_timeout: mem_rd=%b, required 1", tag, mem_rd);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        run   = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        ip_model = RESET_IP;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run   = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        ip_model = RESET_IP;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || illegal !== 1'b0 || mem_rd !== 1'b0 || retire !== 1'b0 ||
                rf_we !== 1'b0 || f_we !== 1'b0 || ip !== RESET_IP) begin
                n_fail++;
                $display("FAIL reset_state: busy=%b illegal=%b mem_rd=%b retire=%b rf_we=%b f_we=%b ip=%h, required all 0 ip=%h",
                         busy, illegal, mem_rd, retire, rf_we, f_we, ip, RESET_IP);
            end
        end
    endtask

    task automatic test_ip_wrap();
        set_reg(REG_C, 8'h41);
        exec_one(8'h0C, 0, "inc_c_wrap");
        n_checks++;
        if (ip !== 16'h0000 || rf[REG_C] !== 8'h42) begin
            n_fail++;
            $display("FAIL ip_wrap: ip=%h C=%h, required 0000 42", ip, rf[REG_C]);
        end
    endtask

    task automatic test_inc_a();
        set_reg(REG_A, 8'h7F);
        set_f(8'h29);
        exec_one(8'h3C, 0, "inc_a");
        n_checks++;
        if (rf[REG_A] !== 8'h80 || f_reg[7] !== 1'b1 || f_reg[4] !== 1'b1 || f_reg[2] !== 1'b1 ||
            f_reg[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL inc_a_result: A=%h F=%h, required A=80 with S,H,V,C set", rf[REG_A], f_reg);
        end
    endtask

    task automatic test_dec_b();
        set_reg(REG_B, 8'h00);
        set_f(8'h00);
        exec_one(8'h05, 0, "dec_b");
        n_checks++;
        if (rf[REG_B] !== 8'hFF || f_reg[7] !== 1'b1 || f_reg[4] !== 1'b1 || f_reg[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL dec_b_result: B=%h F=%h, required B=FF with S,H,N set", rf[REG_B], f_reg);
        end
    endtask

    task automatic test_ready_delay();
        set_reg(REG_L, 8'hFF);
        exec_one(8'h2C, 4, "inc_l_delayed");
        n_checks++;
        if (rf[REG_L] !== 8'h00 || f_reg[6] !== 1'b1 || f_reg[4] !== 1'b1) begin
            n_fail++;
            $display("FAIL inc_l_result: L=%h F=%h, required L=00 with Z,H set", rf[REG_L], f_reg);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ops [3];
        int          retire_at [3];
        int          fetches, retires, cycles;
        logic [15:0] a;
        ops[0] = 8'h04;   // INC B
        ops[1] = 8'h0D;   // DEC C
        ops[2] = 8'h3D;   // DEC A
        fetches = 0; retires = 0; cycles = 0;
        for (int i = 0; i < 3; i++) begin
            retire_at[i] = 0;
            a = ip_model + 16'(i);
            mem[a] = ops[i];
            push_expect(ops[i]);
        end
        ready_delay = 0;
        run = 1'b1;
        while (retires < 3 && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (mem_rd) begin
                fetches++;
                if (fetches == 3) run = 1'b0;
            end
            if (retire) begin
                retire_at[retires] = cycles;
                retires++;
            end
        end
        run = 1'b0;
        n_checks++;
        if (retires != 3 || retire_at[0] != 3 || retire_at[1] != 6 || retire_at[2] != 9) begin
            n_fail++;
            $display("FAIL back_to_back_timing: retires=%0d at %0d,%0d,%0d, required 3 at 3,6,9",
                     retires, retire_at[0], retire_at[1], retire_at[2]);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || ip !== ip_model + 16'd3) begin
            n_fail++;
            $display("FAIL back_to_back_end: busy=%b ip=%h, required 0 %h", busy, ip, ip_model + 16'd3);
        end
        ip_model = ip_model + 16'd3;
    endtask

    task automatic test_reset_fetch_wait();
        mem[ip_model] = 8'h3C;
        ready_delay = 5;
        run = 1'b1;
        wait_fetch("reset_fetch_wait");
        run = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || mem_rd !== 1'b0 || ip !== RESET_IP) begin
            n_fail++;
            $display("FAIL reset_fetch_wait: busy=%b mem_rd=%b ip=%h, required 0 0 %h",
                     busy, mem_rd, ip, RESET_IP);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || mem_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fetch_idle: busy=%b mem_rd=%b, required 0 0", busy, mem_rd);
        end
        ip_model = RESET_IP;
    endtask

    task automatic test_reset_exec();
        logic [7:0] a_before;
        a_before = rf[REG_A];
        mem[ip_model] = 8'h3C;
        ready_delay = 0;
        run = 1'b1;
        wait_fetch("reset_exec");
        run = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rf_we !== 1'b0 || f_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_exec_strobe: rf_we=%b f_we=%b, required 0 0", rf_we, f_we);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || illegal !== 1'b0 || ip !== RESET_IP) begin
            n_fail++;
            $display("FAIL reset_exec_state: busy=%b illegal=%b ip=%h, required 0 0 %h",
                     busy, illegal, ip, RESET_IP);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (rf[REG_A] !== a_before) begin
            n_fail++;
            $display("FAIL reset_exec_no_write: A=%h, required %h", rf[REG_A], a_before);
        end
        ip_model = RESET_IP;
    endtask

    task automatic test_trap();
        logic [7:0] ops [2];
        int         bad;
        ops[0] = 8'h34;   // INC (HL)
        ops[1] = 8'h00;   // NOP
        for (int k = 0; k < 2; k++) begin
            mem[ip_model] = ops[k];
            ready_delay = 0;
            run = 1'b1;
            wait_fetch("trap");
            bad = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (illegal !== 1'b1 || busy !== 1'b0 || mem_rd !== 1'b0 || retire !== 1'b0 ||
                    ip !== ip_model) bad++;
            end
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL trap_%h: illegal=%b busy=%b mem_rd=%b retire=%b ip=%h (%0d bad cycles), required 1 0 0 0 %h",
                         ops[k], illegal, busy, mem_rd, retire, ip, bad, ip_model);
            end
            apply_reset();
            n_checks++;
            if (illegal !== 1'b0 || ip !== RESET_IP) begin
                n_fail++;
                $display("FAIL trap_clear_%h: illegal=%b ip=%h, required 0 %h", ops[k], illegal, ip, RESET_IP);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        run   = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        set_reg(REG_B, 8'h10);
        set_reg(REG_C, 8'h20);
        set_reg(REG_D, 8'h30);
        set_reg(REG_E, 8'h40);
        set_reg(REG_H, 8'h50);
        set_reg(REG_L, 8'h60);
        set_reg(REG_HL_IND, 8'h00);
        set_reg(REG_A, 8'h70);
        set_f(8'h00);

        test_reset();
        test_ip_wrap();
        test_inc_a();
        test_dec_b();
        test_ready_delay();
        test_back_to_back();
        test_reset_fetch_wait();
        test_reset_exec();
        test_trap();

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d writebacks never seen, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
